// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter. Bytes are queued in a 2**FIFO_AW-deep FIFO and
//   sent as 8N1 frames. If UART_TX_PARITY_EN is defined, they are sent as 8E1
//   frames instead.
//
//   Optional feature macro: UART_TX_PARITY_EN. It inserts an even-parity bit
//   between the data bits and the stop bit.
//
//   Ports
//     clk           system clock
//     rst_n         asynchronous active-low reset
//     i_data        byte to queue
//     i_valid       producer strobe; a byte is written when i_valid && o_ready
//     o_ready       FIFO not full
//     o_tx          serial line, idle high, driven from a flop
//     o_busy        frame in progress or FIFO non-empty (registered)
//     o_fifo_count  entries currently queued, 0..2**FIFO_AW
//     o_overflow    sticky; set by a write attempt while full, cleared by reset
module uart_tx_buffered #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_AW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic [FIFO_AW:0] o_fifo_count,
  output logic             o_overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int DEPTH        = 1 << FIFO_AW;
  localparam int PW           = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [7:0]        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic              full, empty, push, pop;
  logic [7:0]        head;
  logic [CNT_W-1:0]  baud_cnt;
  logic              bit_end;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tx_n;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  // The pointers are one bit wider than the address. An equal address with a
  // different MSB means the write side has wrapped once more than the read
  // side, so the FIFO is full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push     = i_valid && !full;
  assign wr_ptr_n = wr_ptr + PW'(push);
  assign rd_ptr_n = rd_ptr + PW'(pop);
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];
  assign bit_end  = (baud_cnt == CNT_LAST);

  assign o_ready      = !full;
  assign o_fifo_count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= i_data;
  end

  // tx_n is the line level for the current state. It is registered into o_tx,
  // so every bit appears on the pad one clock after its state is entered.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        tx_n = shift[0];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_n = par;
        if (bit_end) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      if (i_valid && full) o_overflow <= 1'b1;

      // The counter is held at zero in IDLE, so every frame starts on a
      // fresh bit period.
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CNT_W'(1);

      if (pop) begin
        shift   <= head;
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        par     <= ^head;
`endif
      end else if (state == S_DATA && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      o_tx   <= tx_n;
      // Built from next-state values so that the flop matches
      // the state it will hold after this edge.
      o_busy <= (state_n != S_IDLE) || (wr_ptr_n != rd_ptr_n);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
//   Self-checking bench for uart_tx_buffered at the default parameters
//   (234 clocks per bit, 16-entry FIFO).
//
//   The reference model is a timeline model:
//     - A queue holds the accepted bytes.
//     - The transmitter is free from a known edge onward.
//     - The next frame start is predicted from that edge.
//
//   Each cycle, the model works out the expected values of o_tx, o_busy,
//   o_ready, o_overflow and o_fifo_count.
//
//   Directed checks cover:
//     - reset,
//     - latency,
//     - bit-centre samples,
//     - the full and overflow flags,
//     - reset during a frame.
//
//   A short randomized phase follows the directed checks.
module tb_uart_tx_buffered;

  localparam int CPB   = 27_000_000 / 115200;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready, o_tx, o_busy, o_overflow;
  logic [4:0] o_fifo_count;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  uart_tx_buffered dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_fifo_count (o_fifo_count),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Line level of bit k of the frame for byte d.
  // Bit 0 is the start bit, bits 1..8 are the data bits LSB first,
  // then the optional parity bit, then the stop bit.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic       m_have, m_ovf;
  int         m_S, m_busy_until, m_free_at;
  logic [8:0] exp_vec = 9'b1_0_1_0_00000;

  // Runs on the falling edge.
  //   1. Compares the outputs that follow edge cyc.
  //   2. Predicts what edge cyc+1 will do.
  always @(negedge clk) begin : model
    int   e;
    logic pu, po, etx;
    if (!rst_n) begin
      m_q.delete();
      m_have       = 1'b0;
      m_ovf        = 1'b0;
      m_S          = 0;
      m_busy_until = 0;
      m_free_at    = 0;
      exp_vec      = 9'b1_0_1_0_00000;
    end else begin
      chk("line", {23'd0, o_tx, o_busy, o_ready, o_overflow, o_fifo_count}, {23'd0, exp_vec});
      e  = cyc + 1;
      pu = i_valid && (m_q.size() < DEPTH);
      if (i_valid && m_q.size() == DEPTH) m_ovf = 1'b1;
      po = (m_q.size() > 0) && (e >= m_free_at);
      if (po) begin
        m_cur        = m_q.pop_front();
        m_have       = 1'b1;
        m_S          = e + 1;
        m_busy_until = e + NB * CPB;
        m_free_at    = e + NB * CPB + 1;
      end
      if (pu) m_q.push_back(i_data);
      if (m_have && e >= m_S && e < m_S + NB * CPB) etx = frame_bit(m_cur, (e - m_S) / CPB);
      else                                          etx = 1'b1;
      exp_vec = {etx, (e < m_busy_until) || (m_q.size() > 0), m_q.size() < DEPTH, m_ovf,
                 5'(m_q.size())};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_one(input logic [7:0] d, output int acc);
    @(posedge clk); #1;
    i_data  = d;
    i_valid = 1'b1;
    @(negedge clk);
    acc = cyc + 1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic burst(input logic [7:0] base, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_data  = rnd ? 8'($urandom) : base + 8'(i);
      i_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // Waits a bounded number of cycles for the start bit.
  // Returns the edge after which o_tx first reads low, or -1 on timeout.
  task automatic wait_fall(output int f);
    f = -1;
    for (int i = 0; i < 64 && f < 0; i++) begin
      @(negedge clk);
      if (o_tx == 1'b0) f = cyc;
    end
  endtask

  task automatic send_check(input string tag, input logic [7:0] d);
    int acc, f;
    push_one(d, acc);
    wait_fall(f);
    chk({tag, "_lat"}, (f < 0) ? 32'hFFFF_FFFF : 32'(f - acc), 32'd2);
    if (f >= 0) begin
      for (int k = 0; k < NB; k++) begin
        while (cyc < f + k * CPB + CPB / 2) @(negedge clk);
        chk($sformatf("%s_bit%0d", tag, k), {31'd0, o_tx}, {31'd0, frame_bit(d, k)});
      end
    end
  endtask

  // The bound is driven by the model, so this wait always ends.
  task automatic wait_drain(input int bound);
    int n = 0;
    while ((m_q.size() > 0 || cyc < m_free_at) && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_busy", {31'd0, o_busy}, 32'd0);
    chk("drain_tx", {31'd0, o_tx}, 32'd1);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int acc, f;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, with no writes for 1000 clocks.
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("idle_tx",   {31'd0, o_tx},       32'd1);
    chk("idle_busy", {31'd0, o_busy},     32'd0);
    chk("idle_rdy",  {31'd0, o_ready},    32'd1);
    chk("idle_cnt",  {27'd0, o_fifo_count}, 32'd0);
    chk("idle_ovf",  {31'd0, o_overflow}, 32'd0);

    // Single byte: 2-clock latency, then the bit pattern.
    send_check("a5", 8'hA5);
    wait_drain(5000);

    // One leading frame keeps the transmitter busy.
    // Then 16 writes in a row fill the FIFO.
    burst(8'h55, 1, 1'b0);
    repeat (4) @(posedge clk);
    burst(8'h00, 16, 1'b0);
    @(negedge clk);
    chk("full_rdy", {31'd0, o_ready},    32'd0);
    chk("full_cnt", {27'd0, o_fifo_count}, 32'd16);
    chk("full_ovf", {31'd0, o_overflow}, 32'd0);

    // Two more writes while full are dropped and set the sticky overflow flag.
    burst(8'hEE, 2, 1'b0);
    @(negedge clk);
    chk("ovf_set", {31'd0, o_overflow},   32'd1);
    chk("ovf_cnt", {27'd0, o_fifo_count}, 32'd16);
    wait_drain(45000);
    chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);

    // Reset in the middle of data bit 4 of 0x3C.
    // The line returns high asynchronously.
    push_one(8'h3C, acc);
    wait_fall(f);
    chk("r3c_lat", (f < 0) ? 32'hFFFF_FFFF : 32'(f - acc), 32'd2);
    if (f >= 0) while (cyc < f + 5 * CPB + CPB / 2) @(negedge clk);
    chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx",   {31'd0, o_tx},         32'd1);
    chk("rst_busy", {31'd0, o_busy},       32'd0);
    chk("rst_cnt",  {27'd0, o_fifo_count}, 32'd0);
    chk("rst_ovf",  {31'd0, o_overflow},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_check("r81", 8'h81);
    wait_drain(5000);

    // Parity extremes. These bytes are also valid traffic in 8N1 builds.
    send_check("ff", 8'hFF);
    wait_drain(5000);
    send_check("s07", 8'h07);
    wait_drain(5000);

    // Randomized phase: short random bursts at random spacing.
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 800)) @(posedge clk);
      burst(8'h00, int'($urandom_range(1, 3)), 1'b1);
    end
    wait_drain(20000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
